// File: rtl/pwm_light_top.sv
// pwm_light_top: 64-channel dimmable light controller.
//   Command frames arrive over an 8N1 UART link, each channel keeps an enable bit
//   and a 0..10 brightness level, 64 PWM outputs are driven with a 10-beat period,
//   and every frame is answered with a single response byte.
// Ports:
//   i_clk  system clock, rising edge     i_rst  synchronous active-high reset
//   i_rx   UART receive line (idle 1)    o_tx   UART transmit line (idle 1)
//   o_pwm  PWM outputs, bit n = channel n
// uart: shared 8N1 transceiver, one start, eight data bits LSB first, one stop.
//   o_rx_vld strobes one clock per byte received; i_tx_start launches i_tx_data
//   while o_tx_busy covers the whole character.

module uart #(
  parameter int unsigned g_CLK_FREQ  = 30_000_000,
  parameter int unsigned g_BAUD_RATE = 1_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic       o_tx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_vld,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_start,
  output logic       o_tx_busy
);
  localparam int unsigned c_DIV = g_CLK_FREQ / g_BAUD_RATE;
  localparam int unsigned c_CW  = $clog2(c_DIV + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic       {TX_IDLE, TX_SHIFT} tx_state_t;

  rx_state_t       rx_state_q;
  logic [1:0]      rx_sync_q;
  logic [c_CW-1:0] rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_shift_q;

  tx_state_t       tx_state_q;
  logic [c_CW-1:0] tx_cnt_q;
  logic [3:0]      tx_bit_q;
  logic [9:0]      tx_shift_q;

  // Receiver: start edge, re-check at half a bit, then sample each bit centre.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_state_q <= RX_IDLE;
      rx_sync_q  <= '1;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      o_rx_data  <= '0;
      o_rx_vld   <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], i_rx};
      o_rx_vld  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: if (!rx_sync_q[1]) begin
          rx_cnt_q   <= '0;
          rx_state_q <= RX_START;
        end
        RX_START: if (rx_cnt_q == c_CW'(c_DIV / 2 - 1)) begin
          rx_cnt_q   <= '0;
          rx_bit_q   <= '0;
          rx_state_q <= rx_sync_q[1] ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        RX_DATA: if (rx_cnt_q == c_CW'(c_DIV - 1)) begin
          rx_cnt_q   <= '0;
          rx_shift_q <= {rx_sync_q[1], rx_shift_q[7:1]};
          rx_bit_q   <= rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
        end else begin
          rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        RX_STOP: if (rx_cnt_q == c_CW'(c_DIV - 1)) begin
          rx_state_q <= RX_IDLE;
          if (rx_sync_q[1]) begin
            o_rx_data <= rx_shift_q;
            o_rx_vld  <= 1'b1;
          end
        end else begin
          rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Transmitter: shift {stop, data, start} out LSB first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
      o_tx       <= 1'b1;
      o_tx_busy  <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          o_tx <= 1'b1;
          if (i_tx_start) begin
            tx_shift_q <= {1'b1, i_tx_data, 1'b0};
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            o_tx_busy  <= 1'b1;
            tx_state_q <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          o_tx <= tx_shift_q[0];
          if (tx_cnt_q == c_CW'(c_DIV - 1)) begin
            tx_cnt_q   <= '0;
            tx_shift_q <= {1'b1, tx_shift_q[9:1]};
            tx_bit_q   <= tx_bit_q + 1'b1;
            if (tx_bit_q == 4'd9) begin
              o_tx_busy  <= 1'b0;
              tx_state_q <= TX_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end
endmodule

module pwm_light_top #(
  parameter int unsigned g_CLK_FREQ  = 30_000_000,
  parameter int unsigned g_BAUD_RATE = 1_000_000,
  parameter int unsigned g_BEAT_FREQ = 100_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx,
  output logic        o_tx,
  output logic [63:0] o_pwm
);
  localparam int unsigned c_BEAT_DIV = g_CLK_FREQ / g_BEAT_FREQ;
  localparam int unsigned c_BW       = $clog2(c_BEAT_DIV);

  localparam logic [7:0] c_SOF = 8'h4B;
  localparam logic [7:0] c_EOF = 8'h0D;
  localparam logic [7:0] c_ACK = 8'h06;
  localparam logic [7:0] c_NAK = 8'h15;
  localparam logic [7:0] c_CMD_INIT = 8'h00;
  localparam logic [7:0] c_CMD_EN   = 8'h02;
  localparam logic [7:0] c_CMD_INC  = 8'h0A;
  localparam logic [7:0] c_CMD_DEC  = 8'h12;
  localparam logic [3:0] c_LVL_MAX  = 4'd10;

  typedef enum logic [2:0] {P_IDLE, P_CMD, P_LEN, P_DATA, P_END} parse_state_t;

  logic [7:0]  rx_data;
  logic        rx_vld;
  logic        tx_busy;

  parse_state_t p_state_q;
  logic [7:0]  cmd_q;
  logic [2:0]  len_q;
  logic [2:0]  cnt_q;
  logic [63:0] mask_q;
  logic        exec_q;
  logic        nak_q;

  logic [63:0] enable_q;
  logic [3:0]  level_q [64];
  logic        resp_pend_q;
  logic [7:0]  resp_data_q;
  logic        tx_start_q;
  logic [7:0]  tx_data_q;

  logic [c_BW-1:0] beat_cnt_q;
  logic [3:0]      phase_q;

  uart #(
    .g_CLK_FREQ (g_CLK_FREQ),
    .g_BAUD_RATE(g_BAUD_RATE)
  ) u_uart (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_rx      (i_rx),
    .o_tx      (o_tx),
    .o_rx_data (rx_data),
    .o_rx_vld  (rx_vld),
    .i_tx_data (tx_data_q),
    .i_tx_start(tx_start_q),
    .o_tx_busy (tx_busy)
  );

  // Frame parser; the mask is cleared at LEN so missing upper bytes read as 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      p_state_q <= P_IDLE;
      cmd_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      mask_q    <= '0;
      exec_q    <= 1'b0;
      nak_q     <= 1'b0;
    end else begin
      exec_q <= 1'b0;
      nak_q  <= 1'b0;
      if (rx_vld) begin
        case (p_state_q)
          P_IDLE: if (rx_data == c_SOF) p_state_q <= P_CMD;
          P_CMD: begin
            cmd_q     <= rx_data;
            p_state_q <= P_LEN;
          end
          P_LEN: if (rx_data > 8'd7) begin
            nak_q     <= 1'b1;
            p_state_q <= P_IDLE;
          end else begin
            len_q     <= rx_data[2:0];
            cnt_q     <= '0;
            mask_q    <= '0;
            p_state_q <= P_DATA;
          end
          P_DATA: begin
            mask_q[{cnt_q, 3'b000} +: 8] <= rx_data;
            if (cnt_q == len_q) p_state_q <= P_END;
            else                cnt_q     <= cnt_q + 1'b1;
          end
          P_END: begin
            if (rx_data == c_EOF) exec_q <= 1'b1;
            else                  nak_q  <= 1'b1;
            p_state_q <= P_IDLE;
          end
          default: p_state_q <= P_IDLE;
        endcase
      end
    end
  end

  // Command execution and the single-entry response slot. A response raised in
  // the same cycle the slot drains is written last and therefore stays queued.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      enable_q    <= '0;
      for (int unsigned i = 0; i < 64; i++) level_q[i] <= '0;
      resp_pend_q <= 1'b0;
      resp_data_q <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      tx_start_q <= 1'b0;
      // tx_start_q guard covers the cycle before the uart raises busy
      if (resp_pend_q && !tx_busy && !tx_start_q) begin
        tx_start_q  <= 1'b1;
        tx_data_q   <= resp_data_q;
        resp_pend_q <= 1'b0;
      end
      if (nak_q) begin
        resp_pend_q <= 1'b1;
        resp_data_q <= c_NAK;
      end
      if (exec_q) begin
        resp_pend_q <= 1'b1;
        resp_data_q <= c_ACK;
        case (cmd_q)
          c_CMD_INIT: begin
            enable_q <= '0;
            for (int unsigned i = 0; i < 64; i++) level_q[i] <= '0;
            resp_data_q <= mask_q[7:0];
          end
          c_CMD_EN: enable_q <= mask_q;
          c_CMD_INC:
            for (int unsigned i = 0; i < 64; i++)
              if (mask_q[i] && level_q[i] != c_LVL_MAX) level_q[i] <= level_q[i] + 1'b1;
          c_CMD_DEC:
            for (int unsigned i = 0; i < 64; i++)
              if (mask_q[i] && level_q[i] != 4'd0) level_q[i] <= level_q[i] - 1'b1;
          default: resp_data_q <= c_NAK;
        endcase
      end
    end
  end

  // Beat strobe and 10-step phase; outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      beat_cnt_q <= '0;
      phase_q    <= '0;
      o_pwm      <= '0;
    end else begin
      if (beat_cnt_q == c_BW'(c_BEAT_DIV - 1)) begin
        beat_cnt_q <= '0;
        phase_q    <= (phase_q == 4'd9) ? 4'd0 : phase_q + 1'b1;
      end else begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
      for (int unsigned i = 0; i < 64; i++)
        o_pwm[i] <= enable_q[i] && (phase_q < level_q[i]);
    end
  end
endmodule

// File: tb/tb_pwm_light_top.sv
// tb_pwm_light_top: directed bench for pwm_light_top. A peer UART drives i_rx,
// a monitor decodes o_tx responses, and PWM duty is counted over fixed windows.

module tb_pwm_light_top;
  localparam int BIT = 30;          // clocks per UART bit
  localparam int PER = 3000;        // clocks per PWM period
  localparam logic [63:0] MASK = 64'h00000005_000000F1;  // bits 0,4,5,6,7,32,34
  localparam logic [63:0] MASK_LO = 64'h00000000_000000F1;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        tx;
  logic [63:0] pwm;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] resp_q[$];

  always #5 clk = ~clk;

  pwm_light_top #(
    .g_CLK_FREQ (30_000_000),
    .g_BAUD_RATE(1_000_000),
    .g_BEAT_FREQ(100_000)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rx (rx),
    .o_tx (tx),
    .o_pwm(pwm)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] cmd, input int len, input logic [63:0] m);
    send_byte(8'h4B);
    send_byte(cmd);
    send_byte(8'(len));
    for (int k = 0; k <= len; k++) send_byte(m[8*k +: 8]);
    send_byte(8'h0D);
  endtask

  task automatic pop_resp(input string tag, input logic [7:0] exp);
    int waited = 0;
    while (resp_q.size() == 0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_present"}, 64'(resp_q.size() > 0), 64'd1);
    if (resp_q.size() > 0) check(tag, resp_q.pop_front(), exp);
  endtask

  task automatic measure(input string tag, input int len, input logic [63:0] m, input int exp_hi);
    int cnt[64];
    for (int b = 0; b < 64; b++) cnt[b] = 0;
    repeat (len) begin
      @(negedge clk);
      for (int b = 0; b < 64; b++) if (pwm[b]) cnt[b]++;
    end
    for (int b = 0; b < 64; b++)
      check($sformatf("%s_pwm%0d", tag, b), 64'(cnt[b]), 64'(m[b] ? exp_hi : 0));
  endtask

  // Response monitor: decode each character at bit centres.
  initial begin : tx_mon
    logic [7:0] b;
    @(negedge rst);
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (BIT / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = tx;
        end
        repeat (BIT) @(negedge clk);
        resp_q.push_back(b);
      end
    end
  end

  initial begin : stim
    int seen;
    int tx_low;
    rst = 1'b1;
    rx  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("rst_pwm", pwm, 64'd0);
      check("rst_tx", 64'(tx), 64'd1);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // INIT echoes payload byte 0
    send_byte(8'h4B); send_byte(8'h00); send_byte(8'h00); send_byte(8'h45); send_byte(8'h0D);
    pop_resp("init", 8'h45);

    // enable with all levels 0: outputs stay low
    send_cmd(8'h02, 4, MASK);
    measure("en", 1000, MASK, 0);
    pop_resp("en", 8'h06);

    // level 1: one beat in ten
    send_cmd(8'h0A, 4, MASK);
    measure("inc1", PER, MASK, PER / 10);
    pop_resp("inc1", 8'h06);

    // ten more INCs (eleven total): saturated at 10, constantly high
    for (int i = 0; i < 10; i++) begin
      send_cmd(8'h0A, 4, MASK);
      if (i > 0) pop_resp("inc_n", 8'h06);
    end
    pop_resp("inc_11th", 8'h06);
    measure("sat", 1000, MASK, 1000);

    // ten DECs bring level to 0
    for (int i = 0; i < 10; i++) begin
      send_cmd(8'h12, 4, MASK);
      if (i > 0) pop_resp("dec_n", 8'h06);
    end
    pop_resp("dec_10th", 8'h06);
    measure("dec0", 1000, MASK, 0);

    // extra DEC must not wrap below 0
    send_cmd(8'h12, 4, MASK);
    measure("dec_floor", 1000, MASK, 0);
    pop_resp("dec_floor", 8'h06);

    send_byte(8'h4B); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0D);
    measure("en0", 1000, MASK, 0);
    pop_resp("en0", 8'h06);

    // error frames
    send_byte(8'h4B); send_byte(8'h00); send_byte(8'h09);
    pop_resp("len9", 8'h15);
    send_byte(8'h4B); send_byte(8'h0A); send_byte(8'h00); send_byte(8'hF1); send_byte(8'h0A);
    pop_resp("bad_eof", 8'h15);
    send_byte(8'h4B); send_byte(8'h33); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0D);
    pop_resp("bad_cmd", 8'h15);
    measure("err", 500, MASK, 0);

    // re-enable low channels: the discarded INC must not have raised any level
    send_byte(8'h4B); send_byte(8'h02); send_byte(8'h00); send_byte(8'hF1); send_byte(8'h0D);
    measure("no_inc", 1000, MASK_LO, 0);
    pop_resp("en_lo", 8'h06);
    check("no_extra_resp", 64'(resp_q.size()), 64'd0);

    // reset during transmission returns o_tx high on the next clock
    send_byte(8'h4B); send_byte(8'h00); send_byte(8'h00); send_byte(8'h5A); send_byte(8'h0D);
    seen = 0;
    for (int i = 0; i < 1000 && seen == 0; i++) begin
      @(negedge clk);
      if (tx === 1'b0) seen = 1;
    end
    check("abort_tx_started", 64'(seen), 64'd1);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx_high", 64'(tx), 64'd1);
    check("abort_pwm", pwm, 64'd0);
    rst = 1'b0;
    tx_low = 0;
    repeat (400) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_low++;
    end
    check("abort_tx_idle", 64'(tx_low), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
